tbus_rx: RTL and testbench
==========================

# tbus_rx

Receiving end of the shared tristate bus built from `tbuf` driver cells. It owns the `EN`/`EN_BAR` pair of every driver on one bus segment, grants the bus to one requesting driver at a time, and enforces a break-before-make turnaround. It samples the bus after a settle interval and hands the word downstream on a valid/ready handshake.

## Interface
Parameters:
- `N_DRV`, 4: number of tbuf drivers on the segment (2..16).
- `WIDTH`, 8: bus width in bits.
- `SETTLE`, 2: cycles a grant is held before sampling (≥1).

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RN`  in  1  synchronous, active-low reset.
- `REQ`  in  N_DRV  per-driver bus request, level-sensitive.
- `BUS`  in  WIDTH  resolved tristate bus value.
- `EN`  out  N_DRV  per-driver enable, to tbuf `EN`.
- `EN_BAR`  out  N_DRV  per-driver complement enable, to tbuf `EN_BAR`.
- `ACK`  out  N_DRV  one-cycle pulse to the driver whose word was sampled.
- `DATA`  out  WIDTH  sampled word.
- `SRC`  out  clog2(N_DRV)  index of the driver that produced `DATA`.
- `VALID`  out  1  `DATA`/`SRC` valid.
- `READY`  in  1  downstream accepts `DATA`.

## Operation
- Clock and reset: one clock, `CLK`. Reset `RN` is synchronous and active-low.
- Reset values (applied on the first edge with `RN`=0):
  - `EN`=0, `EN_BAR`=all ones, `ACK`=0.
  - `DATA`=0, `SRC`=0, `VALID`=0.
  - State IDLE. Round-robin pointer = N_DRV-1.
- Enable outputs:
  - `EN` and `EN_BAR` are registered.
  - `EN_BAR[i]` == ~`EN[i]` on every cycle.
  - At most one `EN` bit is set at any time.
- State machine:
  - IDLE: all enables off. If `REQ`≠0, latch the winner into the grant register and go to ARB. Otherwise stay.
  - ARB: all enables off; this is the turnaround cycle. Next state is DRIVE. `EN[g]` rises on entry to DRIVE.
  - DRIVE: `EN[g]`=1, and a counter runs SETTLE cycles. On the last DRIVE cycle:
    - `DATA`<=`BUS`, `SRC`<=g, `ACK[g]` pulses.
    - `EN` clears, and the state goes to HOLD.
  - HOLD: enables off, `VALID`=1. On `VALID`&`READY`, go to IDLE and clear `VALID` on that edge.
- Arbitration:
  - The winner is chosen from the `REQ` value sampled in IDLE.
  - Dropping `REQ` after the grant does not abort the cycle; the bus is still sampled and handed downstream.
- New requests during ARB/DRIVE/HOLD wait; they are never lost while held high.
- Reset mid-operation: enables drop on the same edge, and any HOLD data is discarded.
- `BUS` is sampled only on the last DRIVE cycle and is ignored otherwise; X/Z on the bus outside DRIVE is harmless.

## Timing
- `REQ` high in IDLE at edge t:
  - ARB at t+1.
  - `EN[g]` high from t+2 through t+1+SETTLE.
  - `VALID` high from t+2+SETTLE.
- With SETTLE=2, `VALID` asserts 4 cycles after the request is seen.
- Turnaround: at least 1 cycle with all `EN`=0 between any two grants. This holds because both HOLD and ARB have enables off.
- Back-to-back throughput with `READY` tied high: one word every SETTLE+3 cycles.
- `ACK[g]` is high for exactly one cycle, concurrent with the `DATA` load edge.

## Configuration
- `TBUS_RX_RR_EN` defined: round-robin arbitration.
  - The search starts at pointer+1 modulo N_DRV.
  - The pointer updates to g on every grant.
- `TBUS_RX_RR_EN` undefined: fixed priority, lowest index wins. The pointer logic is not built.

## Test plan
- Reset: hold `RN`=0 for 2 cycles with `REQ`=4'b1111 → `EN`=0, `EN_BAR`=4'b1111, `VALID`=0. The first grant goes to driver 0 in both configurations.
- Single transfer: `REQ`=4'b0100, `BUS`=8'hA5, SETTLE=2 →
  - `EN`=4'b0100 for 2 cycles, `EN_BAR`=4'b1011.
  - `VALID` at t+4 with `DATA`=8'hA5, `SRC`=2, and `ACK[2]` pulsed once.
- Contention-free handover: `REQ`=4'b0011 held, `READY`=1 → `EN` never has two bits set, and ≥1 all-zero cycle separates grants.
  - With `TBUS_RX_RR_EN`: grants go 0,1,0,1.
  - Without it: grants go 0,0,0.
- Backpressure: `READY`=0 for 10 cycles during HOLD → `VALID`, `DATA`, `SRC` stable. No new `EN` is asserted until the cycle after `READY`=1.
- Reset mid-DRIVE: `RN`=0 on the first DRIVE cycle → `EN`=0 and `EN_BAR`=all ones on that edge, and no `ACK` or `VALID` follows.
- Request withdrawn: `REQ[3]` drops during DRIVE → the transfer still completes with `SRC`=3, and the next IDLE ignores driver 3.

Source files
------------

// File: rtl/tbus_rx.sv
// Receiving end of a tbuf-driven tristate bus segment: grants one driver at a time
// with a break-before-make turnaround, samples after SETTLE cycles, hands off on valid/ready.
// Optional feature: define TBUS_RX_RR_EN for round-robin arbitration (default fixed priority).
module tbus_rx #(
  parameter int N_DRV  = 4,
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic                       CLK,
  input  logic                       RN,
  input  logic [N_DRV-1:0]           REQ,
  input  logic [WIDTH-1:0]           BUS,
  output logic [N_DRV-1:0]           EN,
  output logic [N_DRV-1:0]           EN_BAR,
  output logic [N_DRV-1:0]           ACK,
  output logic [WIDTH-1:0]           DATA,
  output logic [$clog2(N_DRV)-1:0]   SRC,
  output logic                       VALID,
  input  logic                       READY
);

  localparam int SRC_W = $clog2(N_DRV);
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_DRIVE, S_HOLD} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SRC_W-1:0]   grant;
  logic [SRC_W-1:0]   win;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_last;
  logic               grant_ld;
  logic               load;
  logic               valid_nxt;
  logic [N_DRV-1:0]   en_nxt;
  logic [N_DRV-1:0]   ack_nxt;

`ifdef TBUS_RX_RR_EN
  logic [SRC_W-1:0]   ptr;
  logic [SRC_W-1:0]   idx;
  logic               found;

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    win   = ptr;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_DRV; i++) begin
      idx = SRC_W'((int'(ptr) + 1 + i) % N_DRV);
      if (!found && REQ[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RN)           ptr <= SRC_W'(N_DRV - 1);
    else if (grant_ld) ptr <= win;
  end
`else
  always_comb begin
    win = '0;
    for (int i = N_DRV - 1; i >= 0; i--) begin
      if (REQ[i]) win = SRC_W'(i);
    end
  end
`endif

  assign cnt_last = (cnt == CNT_W'(SETTLE - 1));

  always_ff @(posedge CLK) begin
    if (!RN) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|REQ) state_nxt = S_ARB;
      S_ARB:   state_nxt = S_DRIVE;
      S_DRIVE: if (cnt_last) state_nxt = S_HOLD;
      S_HOLD:  if (VALID && READY) state_nxt = S_IDLE;
    endcase
  end

  // Enables follow the next state, so ARB and HOLD both leave the bus undriven.
  always_comb begin
    grant_ld  = (state == S_IDLE) && (|REQ);
    load      = (state == S_DRIVE) && cnt_last;
    en_nxt    = '0;
    ack_nxt   = '0;
    valid_nxt = VALID;
    if (state_nxt == S_DRIVE) en_nxt[grant] = 1'b1;
    if (load) begin
      ack_nxt[grant] = 1'b1;
      valid_nxt      = 1'b1;
    end else if (VALID && READY) begin
      valid_nxt      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      EN     <= '0;
      EN_BAR <= '1;
      ACK    <= '0;
      DATA   <= '0;
      SRC    <= '0;
      VALID  <= 1'b0;
      grant  <= '0;
      cnt    <= '0;
    end else begin
      EN     <= en_nxt;
      EN_BAR <= ~en_nxt;
      ACK    <= ack_nxt;
      VALID  <= valid_nxt;
      if (grant_ld) grant <= win;
      if (state == S_ARB)        cnt <= '0;
      else if (state == S_DRIVE) cnt <= cnt + CNT_W'(1);
      if (load) begin
        DATA <= BUS;
        SRC  <= grant;
      end
    end
  end

endmodule

// File: tb/tb_tbus_rx.sv
// Directed testbench for tbus_rx (N_DRV=4, WIDTH=8, SETTLE=2); expectations
// follow TBUS_RX_RR_EN when the bench is built with it.
module tb_tbus_rx;

  logic       CLK;
  logic       RN;
  logic [3:0] REQ;
  logic [7:0] BUS;
  logic [3:0] EN;
  logic [3:0] EN_BAR;
  logic [3:0] ACK;
  logic [7:0] DATA;
  logic [1:0] SRC;
  logic       VALID;
  logic       READY;

  int vec_cnt = 0;
  int err_cnt = 0;

  tbus_rx #(.N_DRV(4), .WIDTH(8), .SETTLE(2)) dut (
    .CLK(CLK), .RN(RN), .REQ(REQ), .BUS(BUS), .EN(EN), .EN_BAR(EN_BAR),
    .ACK(ACK), .DATA(DATA), .SRC(SRC), .VALID(VALID), .READY(READY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RN = 1'b0; REQ = 4'b1111; READY = 1'b0; BUS = 8'h00;
    step(); step();
    vec_cnt++; if (EN !== 4'b0000) begin err_cnt++; $display("FAIL reset_en got=%b exp=0000", EN); end
    vec_cnt++; if (EN_BAR !== 4'b1111) begin err_cnt++; $display("FAIL reset_en_bar got=%b exp=1111", EN_BAR); end
    vec_cnt++; if (VALID !== 1'b0 || ACK !== 4'b0000) begin err_cnt++; $display("FAIL reset_valid_ack got=%b/%b exp=0/0000", VALID, ACK); end
    vec_cnt++; if (DATA !== 8'h00 || SRC !== 2'd0) begin err_cnt++; $display("FAIL reset_data_src got=%h/%0d exp=00/0", DATA, SRC); end
    RN = 1'b1;
    step();
    vec_cnt++; if (EN !== 4'b0000) begin err_cnt++; $display("FAIL reset_arb_en got=%b exp=0000", EN); end
    step();
    vec_cnt++; if (EN !== 4'b0001) begin err_cnt++; $display("FAIL reset_first_grant got=%b exp=0001", EN); end
    step(); step();
    vec_cnt++; if (VALID !== 1'b1 || SRC !== 2'd0 || ACK !== 4'b0001) begin
      err_cnt++; $display("FAIL reset_first_word got=v%b src%0d ack%b exp=v1 src0 ack0001", VALID, SRC, ACK);
    end
    REQ = 4'b0000; READY = 1'b1;
    step();
    vec_cnt++; if (VALID !== 1'b0) begin err_cnt++; $display("FAIL reset_accept got=%b exp=0", VALID); end
    READY = 1'b0;
  endtask

  task automatic test_single();
    REQ = 4'b0100; BUS = 8'hxx; READY = 1'b0;
    step();
    REQ = 4'b0000;
    vec_cnt++; if (EN !== 4'b0000) begin err_cnt++; $display("FAIL single_arb got=%b exp=0000", EN); end
    step();
    BUS = 8'hA5;
    vec_cnt++; if (EN !== 4'b0100 || EN_BAR !== 4'b1011 || ACK !== 4'b0000) begin
      err_cnt++; $display("FAIL single_drive1 got=%b/%b/%b exp=0100/1011/0000", EN, EN_BAR, ACK);
    end
    step();
    vec_cnt++; if (EN !== 4'b0100 || VALID !== 1'b0) begin err_cnt++; $display("FAIL single_drive2 got=%b/%b exp=0100/0", EN, VALID); end
    step();
    BUS = 8'hxx;
    vec_cnt++; if (VALID !== 1'b1 || DATA !== 8'hA5 || SRC !== 2'd2) begin
      err_cnt++; $display("FAIL single_word got=v%b %h src%0d exp=v1 a5 src2", VALID, DATA, SRC);
    end
    vec_cnt++; if (ACK !== 4'b0100 || EN !== 4'b0000 || EN_BAR !== 4'b1111) begin
      err_cnt++; $display("FAIL single_ack got=ack%b en%b bar%b exp=0100/0000/1111", ACK, EN, EN_BAR);
    end
    step();
    vec_cnt++; if (ACK !== 4'b0000 || VALID !== 1'b1) begin err_cnt++; $display("FAIL single_ack_pulse got=%b/%b exp=0000/1", ACK, VALID); end
    READY = 1'b1;
    step();
    vec_cnt++; if (VALID !== 1'b0) begin err_cnt++; $display("FAIL single_accept got=%b exp=0", VALID); end
    READY = 1'b0;
  endtask

  task automatic test_handover();
    logic [1:0] exp_src [4];
    logic [3:0] prev_en;
    int         got;
`ifdef TBUS_RX_RR_EN
    exp_src = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
    exp_src = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    REQ = 4'b0011; READY = 1'b1; BUS = 8'h11;
    prev_en = EN;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      step();
      vec_cnt++; if ($countones(EN) > 1 || EN_BAR !== ~EN) begin
        err_cnt++; $display("FAIL handover_onehot got=en%b bar%b exp=onehot/complement", EN, EN_BAR);
      end
      vec_cnt++; if (prev_en !== 4'b0000 && EN !== 4'b0000 && EN !== prev_en) begin
        err_cnt++; $display("FAIL handover_gap got=%b after %b exp=idle cycle between", EN, prev_en);
      end
      if (ACK !== 4'b0000) begin
        vec_cnt++; if (SRC !== exp_src[got] || ACK !== (4'b0001 << exp_src[got])) begin
          err_cnt++; $display("FAIL handover_order%0d got=src%0d ack%b exp=src%0d", got, SRC, ACK, exp_src[got]);
        end
        got++;
      end
      prev_en = EN;
    end
    vec_cnt++; if (got !== 4) begin err_cnt++; $display("FAIL handover_count got=%0d exp=4", got); end
    REQ = 4'b0000;
    step(); step();
    READY = 1'b0;
  endtask

  task automatic test_backpressure();
    REQ = 4'b0010; READY = 1'b0; BUS = 8'hxx;
    step(); step();
    BUS = 8'h3C;
    step(); step();
    for (int c = 0; c < 10; c++) begin
      BUS = 8'($urandom);
      vec_cnt++; if (VALID !== 1'b1 || DATA !== 8'h3C || SRC !== 2'd1 || EN !== 4'b0000) begin
        err_cnt++; $display("FAIL backpressure_hold%0d got=v%b %h src%0d en%b exp=v1 3c src1 en0000", c, VALID, DATA, SRC, EN);
      end
      step();
    end
    READY = 1'b1;
    step();
    vec_cnt++; if (VALID !== 1'b0 || EN !== 4'b0000) begin err_cnt++; $display("FAIL backpressure_release got=%b/%b exp=0/0000", VALID, EN); end
    step();
    vec_cnt++; if (EN !== 4'b0000) begin err_cnt++; $display("FAIL backpressure_arb got=%b exp=0000", EN); end
    step();
    vec_cnt++; if (EN !== 4'b0010) begin err_cnt++; $display("FAIL backpressure_regrant got=%b exp=0010", EN); end
    REQ = 4'b0000;
    step(); step(); step();
    READY = 1'b0;
  endtask

  task automatic test_reset_mid_drive();
    REQ = 4'b1000; READY = 1'b1; BUS = 8'h77;
    step(); step();
    vec_cnt++; if (EN !== 4'b1000) begin err_cnt++; $display("FAIL midrst_drive got=%b exp=1000", EN); end
    RN = 1'b0;
    step();
    vec_cnt++; if (EN !== 4'b0000 || EN_BAR !== 4'b1111 || VALID !== 1'b0 || ACK !== 4'b0000) begin
      err_cnt++; $display("FAIL midrst_edge got=en%b bar%b v%b ack%b exp=0000/1111/0/0000", EN, EN_BAR, VALID, ACK);
    end
    RN = 1'b1; REQ = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      step();
      vec_cnt++; if (ACK !== 4'b0000 || VALID !== 1'b0 || EN !== 4'b0000) begin
        err_cnt++; $display("FAIL midrst_after%0d got=ack%b v%b en%b exp=0000/0/0000", c, ACK, VALID, EN);
      end
    end
    READY = 1'b0;
  endtask

  task automatic test_withdraw();
    REQ = 4'b1000; READY = 1'b0; BUS = 8'hxx;
    step(); step();
    vec_cnt++; if (EN !== 4'b1000) begin err_cnt++; $display("FAIL withdraw_drive got=%b exp=1000", EN); end
    REQ = 4'b0000; BUS = 8'h5A;
    step(); step();
    BUS = 8'hxx;
    vec_cnt++; if (VALID !== 1'b1 || SRC !== 2'd3 || DATA !== 8'h5A || ACK !== 4'b1000) begin
      err_cnt++; $display("FAIL withdraw_word got=v%b src%0d %h ack%b exp=v1 src3 5a 1000", VALID, SRC, DATA, ACK);
    end
    READY = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      step();
      vec_cnt++; if (EN !== 4'b0000 || VALID !== 1'b0) begin
        err_cnt++; $display("FAIL withdraw_idle%0d got=en%b v%b exp=0000/0", c, EN, VALID);
      end
    end
    READY = 1'b0;
  endtask

  initial begin
    RN = 1'b0; REQ = 4'b0000; BUS = 8'h00; READY = 1'b0;
    test_reset();
    test_single();
    test_handover();
    test_backpressure();
    test_reset_mid_drive();
    test_withdraw();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
